// File: rtl/sin_dds_pkg.sv
// ============================================================================
// Module   : sin_dds_pkg
// Brief    : Shared constants and quarter-wave ROM contents for sin_dds_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sin_dds_pkg;

    localparam int         c_QUAD_W          = 2;
    localparam logic [1:0] c_COS_QUAD_OFFSET = 2'd1;
    localparam int         c_TAYLOR_TERMS    = 12;
    // pi/2 in unsigned Q2.62
    localparam logic [63:0] c_HALF_PI_Q62    = 64'h6487_ED51_10B4_611A;

    // Rounded magnitude of the half-LSB-offset quarter sine, computed in Q62
    // fixed point so the table is elaboration-time constant without real math.
    function automatic logic [63:0] rom_entry(input int idx, input int data_w, input int lut_aw);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc;
        logic [127:0] amp;
        logic [127:0] prod;
        x    = ({64'd0, c_HALF_PI_Q62} * 128'(2 * idx + 1)) >> (lut_aw + 1);
        x2   = (x * x) >> 62;
        term = x;
        acc  = x;
        for (int k = 1; k <= c_TAYLOR_TERMS; k++) begin
            term = ((term * x2) >> 62) / 128'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1) acc = acc - term;
            else              acc = acc + term;
        end
        amp  = (128'd1 << (data_w - 1)) - 128'd1;
        prod = (acc * amp + (128'd1 << 61)) >> 62;
        return prod[63:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sin_dds_gen_if.sv
// ============================================================================
// Module   : sin_dds_gen_if
// Brief    : Control and sample-stream bundle of the DDS sine generator.
// Options  : SIN_DDS_COS_EN adds the cos_out sample lane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sin_dds_gen_if #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 32
);
    logic                     en;
    logic [PHASE_W-1:0]       fcw_in;
    logic                     fcw_we;
    logic                     phase_clr;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] sin_out;
`ifdef SIN_DDS_COS_EN
    logic signed [DATA_W-1:0] cos_out;
`endif

    modport master (
        output en, fcw_in, fcw_we, phase_clr, out_ready,
        input  out_valid, sin_out
`ifdef SIN_DDS_COS_EN
        , input cos_out
`endif
    );

    modport slave (
        input  en, fcw_in, fcw_we, phase_clr, out_ready,
        output out_valid, sin_out
`ifdef SIN_DDS_COS_EN
        , output cos_out
`endif
    );
endinterface

`default_nettype wire

// File: rtl/sin_quarter_rom.sv
// ============================================================================
// Module   : sin_quarter_rom
// Brief    : Registered quarter-wave sine magnitude ROM, one or two read ports.
// Options  : SIN_DDS_COS_EN enables the second read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_quarter_rom
    import sin_dds_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LUT_AW = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_en,
    input  wire logic [LUT_AW-1:0] i_addr0,
    output logic      [DATA_W-2:0] o_data0
`ifdef SIN_DDS_COS_EN
    ,
    input  wire logic [LUT_AW-1:0] i_addr1,
    output logic      [DATA_W-2:0] o_data1
`endif
);
    localparam int c_DEPTH = 1 << LUT_AW;

    logic [DATA_W-2:0] w_rom [c_DEPTH];

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
        localparam logic [63:0] c_ENTRY = rom_entry(gi, DATA_W, LUT_AW);
        assign w_rom[gi] = c_ENTRY[DATA_W-2:0];
    end

    logic [DATA_W-2:0] r_data0_q;
    logic [DATA_W-2:0] w_data0_d;
`ifdef SIN_DDS_COS_EN
    logic [DATA_W-2:0] r_data1_q;
    logic [DATA_W-2:0] w_data1_d;
`endif

    always_comb begin
        w_data0_d = r_data0_q;
        if (i_en) w_data0_d = w_rom[i_addr0];
`ifdef SIN_DDS_COS_EN
        w_data1_d = r_data1_q;
        if (i_en) w_data1_d = w_rom[i_addr1];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0_q <= '0;
`ifdef SIN_DDS_COS_EN
            r_data1_q <= '0;
`endif
        end else begin
            r_data0_q <= w_data0_d;
`ifdef SIN_DDS_COS_EN
            r_data1_q <= w_data1_d;
`endif
        end
    end

    assign o_data0 = r_data0_q;
`ifdef SIN_DDS_COS_EN
    assign o_data1 = r_data1_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sin_dds_gen.sv
// ============================================================================
// Module   : sin_dds_gen
// Brief    : Phase-accumulator sine generator, quarter-wave ROM, valid/ready out.
// Options  : SIN_DDS_COS_EN adds a quadrature cos_out lane in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_dds_gen
    import sin_dds_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LUT_AW  = 8,
    parameter int PHASE_W = 32
) (
    input wire logic     clk,
    input wire logic     rst,
    sin_dds_gen_if.slave bus
);
    localparam int c_IDX_W = LUT_AW + c_QUAD_W;

    logic                w_adv;
    logic [PHASE_W-1:0]  r_phase_q,  w_phase_d;
    logic [PHASE_W-1:0]  r_fcw_q,    w_fcw_d;
    logic                r_v0_q,     w_v0_d;
    logic [c_IDX_W-1:0]  r_idx0_q,   w_idx0_d;
    logic                r_v1_q,     w_v1_d;
    logic                r_sign1_q,  w_sign1_d;
    logic                r_valid_q,  w_valid_d;
    logic [DATA_W-1:0]   r_sin_q,    w_sin_d;
    logic [1:0]          w_quad;
    logic [LUT_AW-1:0]   w_frac;
    logic [LUT_AW-1:0]   w_addr_sin;
    logic [DATA_W-2:0]   w_mag_sin;
    logic [DATA_W-1:0]   w_ext_sin;
`ifdef SIN_DDS_COS_EN
    logic                r_csign1_q, w_csign1_d;
    logic [DATA_W-1:0]   r_cos_q,    w_cos_d;
    logic [1:0]          w_cquad;
    logic [LUT_AW-1:0]   w_addr_cos;
    logic [DATA_W-2:0]   w_mag_cos;
    logic [DATA_W-1:0]   w_ext_cos;
`endif

    // A stalled output freezes every stage, including the accumulator.
    assign w_adv     = !r_valid_q || bus.out_ready;
    assign w_ext_sin = {1'b0, w_mag_sin};
`ifdef SIN_DDS_COS_EN
    assign w_ext_cos = {1'b0, w_mag_cos};
`endif

    always_comb begin
        w_fcw_d   = bus.fcw_we ? bus.fcw_in : r_fcw_q;
        w_phase_d = r_phase_q;
        if (w_adv && bus.en) w_phase_d = r_phase_q + r_fcw_q;
        if (bus.phase_clr)   w_phase_d = '0;
        w_v0_d    = w_adv ? bus.en : r_v0_q;
        w_idx0_d  = (w_adv && bus.en) ? r_phase_q[PHASE_W-1 -: c_IDX_W] : r_idx0_q;

        // Odd quadrants read the quarter table backwards; upper half negates.
        w_quad     = r_idx0_q[c_IDX_W-1 -: c_QUAD_W];
        w_frac     = r_idx0_q[LUT_AW-1:0];
        w_addr_sin = w_quad[0] ? ~w_frac : w_frac;
        w_v1_d     = w_adv ? r_v0_q : r_v1_q;
        w_sign1_d  = w_adv ? w_quad[1] : r_sign1_q;

        w_valid_d  = w_adv ? r_v1_q : r_valid_q;
        w_sin_d    = r_sin_q;
        if (w_adv && r_v1_q) w_sin_d = r_sign1_q ? -w_ext_sin : w_ext_sin;
`ifdef SIN_DDS_COS_EN
        w_cquad    = w_quad + c_COS_QUAD_OFFSET;
        w_addr_cos = w_cquad[0] ? ~w_frac : w_frac;
        w_csign1_d = w_adv ? w_cquad[1] : r_csign1_q;
        w_cos_d    = r_cos_q;
        if (w_adv && r_v1_q) w_cos_d = r_csign1_q ? -w_ext_cos : w_ext_cos;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_q  <= '0;
            r_fcw_q    <= '0;
            r_v0_q     <= 1'b0;
            r_idx0_q   <= '0;
            r_v1_q     <= 1'b0;
            r_sign1_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            r_sin_q    <= '0;
`ifdef SIN_DDS_COS_EN
            r_csign1_q <= 1'b0;
            r_cos_q    <= '0;
`endif
        end else begin
            r_phase_q  <= w_phase_d;
            r_fcw_q    <= w_fcw_d;
            r_v0_q     <= w_v0_d;
            r_idx0_q   <= w_idx0_d;
            r_v1_q     <= w_v1_d;
            r_sign1_q  <= w_sign1_d;
            r_valid_q  <= w_valid_d;
            r_sin_q    <= w_sin_d;
`ifdef SIN_DDS_COS_EN
            r_csign1_q <= w_csign1_d;
            r_cos_q    <= w_cos_d;
`endif
        end
    end

    sin_quarter_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_adv),
        .i_addr0 (w_addr_sin),
        .o_data0 (w_mag_sin)
`ifdef SIN_DDS_COS_EN
        ,
        .i_addr1 (w_addr_cos),
        .o_data1 (w_mag_cos)
`endif
    );

    assign bus.out_valid = r_valid_q;
    assign bus.sin_out   = r_sin_q;
`ifdef SIN_DDS_COS_EN
    assign bus.cos_out   = r_cos_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sin_dds_gen.sv
// ============================================================================
// Module   : tb_sin_dds_gen
// Brief    : Randomised self-checking bench for sin_dds_gen against a real-valued sine model.
// Options  : SIN_DDS_COS_EN also checks cos_out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sin_dds_gen;
    localparam int  DATA_W      = 16;
    localparam int  LUT_AW      = 8;
    localparam int  PHASE_W     = 32;
    localparam int  c_IDX_SHIFT = PHASE_W - LUT_AW - 2;
    localparam real c_PI        = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sin_dds_gen_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus_if ();

    sin_dds_gen #(
        .DATA_W  (DATA_W),
        .LUT_AW  (LUT_AW),
        .PHASE_W (PHASE_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the phase selects one of 4*2^LUT_AW bins, sampled at bin centre.
    function automatic int ref_wave(input logic [PHASE_W-1:0] ph, input bit cosine);
        int  idx;
        real th;
        real r;
        idx = int'(ph >> c_IDX_SHIFT);
        th  = 2.0 * c_PI * (real'(idx) + 0.5) / real'(1 << (LUT_AW + 2));
        if (cosine) th = th + c_PI / 2.0;
        r   = real'((1 << (DATA_W - 1)) - 1) * $sin(th);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    logic [PHASE_W-1:0] m_phase = '0;
    logic [PHASE_W-1:0] m_fcw   = '0;
    bit                 m_v [3] = '{default: 1'b0};
    int                 m_s [3] = '{default: 0};
    int                 m_c [3] = '{default: 0};

    bit acc_fire;
    int acc_sin;
    int acc_cos;

    // One clock: called and returning at a falling edge.
    task automatic cycle(input bit en_i, input bit rdy_i, input bit we_i,
                         input logic [PHASE_W-1:0] fcw_i, input bit clr_i, input bit rst_i);
        bit adv;
        acc_fire = bus_if.out_valid && rdy_i && !rst_i;
        acc_sin  = int'(bus_if.sin_out);
`ifdef SIN_DDS_COS_EN
        acc_cos  = int'(bus_if.cos_out);
`else
        acc_cos  = 0;
`endif
        bus_if.en        = en_i;
        bus_if.out_ready = rdy_i;
        bus_if.fcw_we    = we_i;
        bus_if.fcw_in    = fcw_i;
        bus_if.phase_clr = clr_i;
        rst              = rst_i;
        if (rst_i) begin
            m_phase = '0;
            m_fcw   = '0;
            m_v     = '{default: 1'b0};
            m_s     = '{default: 0};
            m_c     = '{default: 0};
        end else begin
            adv = !m_v[2] || rdy_i;
            if (adv) begin
                if (m_v[1]) begin
                    m_s[2] = m_s[1];
                    m_c[2] = m_c[1];
                end
                m_v[2] = m_v[1];
                m_v[1] = m_v[0];
                m_s[1] = m_s[0];
                m_c[1] = m_c[0];
                m_v[0] = en_i;
                if (en_i) begin
                    m_s[0]  = ref_wave(m_phase, 1'b0);
                    m_c[0]  = ref_wave(m_phase, 1'b1);
                    m_phase = m_phase + m_fcw;
                end
            end
            if (clr_i) m_phase = '0;
            if (we_i)  m_fcw   = fcw_i;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("out_valid", longint'(bus_if.out_valid), longint'(m_v[2]));
        if (m_v[2]) begin
            check_val("sin_out", longint'(bus_if.sin_out), longint'(m_s[2]));
`ifdef SIN_DDS_COS_EN
            check_val("cos_out", longint'(bus_if.cos_out), longint'(m_c[2]));
`endif
        end
    endtask

    initial begin
        int lat;
        int n_acc;
        bus_if.en        = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.fcw_we    = 1'b0;
        bus_if.fcw_in    = '0;
        bus_if.phase_clr = 1'b0;
        @(negedge clk);

        repeat (10) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_val("rst_valid", longint'(bus_if.out_valid), 0);
        check_val("rst_sin", longint'(bus_if.sin_out), 0);

        // Steady sweep at one bin per sample.
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
        lat = 0;
        for (int i = 0; i < 10 && !bus_if.out_valid; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            lat++;
        end
        check_val("first_valid_lat", lat, 3);
        n_acc = 0;
        repeat (1100) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (acc_fire) begin
                if (n_acc == 0) begin
                    check_val("s0", acc_sin, 101);
`ifdef SIN_DDS_COS_EN
                    check_val("c0", acc_cos, 32767);
`endif
                end
                if (n_acc == 255)  check_val("s255", acc_sin, 32767);
                if (n_acc == 256)  check_val("s256", acc_sin, 32767);
                if (n_acc == 512)  check_val("s512", acc_sin, -101);
                if (n_acc == 1024) check_val("s1024_period", acc_sin, 101);
                n_acc++;
            end
        end

        // Random backpressure, then a mid-stream tuning-word change.
        repeat (600) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 32'h0080_0000, 1'b0, 1'b0);
        repeat (300) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);

        // Phase clear while streaming: the fourth acceptance here is the first zero-phase sample.
        repeat (5) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        n_acc = 0;
        repeat (8) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (acc_fire) begin
                n_acc++;
                if (n_acc == 4) check_val("clr_restart", acc_sin, 101);
            end
        end

        // Reverse sweep from zero phase.
        repeat (5) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hFFC0_0000, 1'b1, 1'b0);
        n_acc = 0;
        repeat (1100) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            if (acc_fire) begin
                if (n_acc == 0) check_val("rev_s0", acc_sin, 101);
                if (n_acc == 1) check_val("rev_s1", acc_sin, -101);
                n_acc++;
            end
        end

        // Everything random together.
        repeat (3000) begin
            cycle(1'(($urandom % 4) != 0), 1'($urandom_range(0, 1)),
                  1'(($urandom % 64) == 0), PHASE_W'($urandom),
                  1'(($urandom % 50) == 0), 1'(($urandom % 500) == 0));
        end

        // Reset while stalled with data held on the output.
        cycle(1'b0, 1'b1, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("stall_valid", longint'(bus_if.out_valid), 1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_val("rst_stall_valid", longint'(bus_if.out_valid), 0);
        check_val("rst_stall_sin", longint'(bus_if.sin_out), 0);
        repeat (20) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
